serial_bus_master: RTL and testbench

SERIAL_BUS_MASTER -- requirements
Module: serial_bus_master

---
 rtl/serial_bus_master.sv | 180 ++++++++++++++++++
 tb/tb_serial_bus_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_bus_master.sv
// Serial bus master: shifts address and write data out LSB first, shifts read
// data in LSB first, and waits a bounded number of cycles for each slave ACK.
module serial_bus_master #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              M_VALID,
   input  logic              M_RW,
   input  logic [ADDR_W-1:0] M_ADDR,
   input  logic [DATA_W-1:0] M_WDATA,
   output logic              M_READY,
   output logic              M_DONE,
   output logic              M_ERR,
   output logic [DATA_W-1:0] M_RDATA,
   output logic              AD_SEL,
   output logic              B_RW,
   output logic              B_BUS_OUT,
   input  logic              B_BUS_IN,
   input  logic              B_ACK,
   input  logic              B_SBSY
);

   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int WC_W  = $clog2(ACK_TIMEOUT + 1);

   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ACK_A,
      S_WDATA,
      S_ACK_W,
      S_RDATA
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [WC_W-1:0]   wcnt, wcnt_nx;
   logic              done_nx, err_nx;
   logic              accept, rd_last;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rd_q;
   logic              rw_q;
   logic              sbsy_unused;

   assign sbsy_unused = B_SBSY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= S_IDLE;
         cnt    <= '0;
         wcnt   <= '0;
         M_DONE <= 1'b0;
         M_ERR  <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         wcnt   <= wcnt_nx;
         M_DONE <= done_nx;
         M_ERR  <= err_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      wcnt_nx  = wcnt;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      accept   = 1'b0;
      rd_last  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (M_VALID) begin
               accept   = 1'b1;
               state_nx = S_ADDR;
               cnt_nx   = '0;
            end
         end
         S_ADDR: begin
            if (cnt == ADDR_LAST) begin
               state_nx = S_ACK_A;
               cnt_nx   = '0;
               wcnt_nx  = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_ACK_A, S_ACK_W: begin
            // An ACK in the final wait cycle beats the timeout
            if (B_ACK) begin
               wcnt_nx = '0;
               cnt_nx  = '0;
               if (state == S_ACK_W) begin
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end else begin
                  state_nx = rw_q ? S_WDATA : S_RDATA;
               end
            end else if (wcnt == WAIT_LAST) begin
               err_nx   = 1'b1;
               wcnt_nx  = '0;
               state_nx = S_IDLE;
            end else begin
               wcnt_nx = wcnt + WC_W'(1);
            end
         end
         S_WDATA: begin
            if (cnt == DATA_LAST) begin
               state_nx = S_ACK_W;
               cnt_nx   = '0;
               wcnt_nx  = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         S_RDATA: begin
            if (cnt == DATA_LAST) begin
               rd_last  = 1'b1;
               done_nx  = 1'b1;
               cnt_nx   = '0;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Address and write data shift out from bit 0; read data shifts in at the top
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_q  <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         M_RDATA <= '0;
      end else begin
         if (accept) begin
            addr_q <= M_ADDR;
            wd_q   <= M_WDATA;
            rw_q   <= M_RW;
         end
         if (state == S_ADDR) begin
            addr_q <= addr_q >> 1;
         end
         if (state == S_WDATA) begin
            wd_q <= wd_q >> 1;
         end
         if (state == S_RDATA) begin
            rd_q <= {B_BUS_IN, rd_q[DATA_W-1:1]};
         end
         if (rd_last) begin
            M_RDATA <= {B_BUS_IN, rd_q[DATA_W-1:1]};
         end
      end
   end

   always_comb begin
      M_READY   = (state == S_IDLE);
      AD_SEL    = (state == S_ADDR);
      B_RW      = (state != S_IDLE) && rw_q;
      B_BUS_OUT = 1'b0;
      if (state == S_ADDR) begin
         B_BUS_OUT = addr_q[0];
      end else if (state == S_WDATA) begin
         B_BUS_OUT = wd_q[0];
      end
   end

endmodule

// File: tb/tb_serial_bus_master.sv
// Directed and random transactions checked cycle by cycle against a
// timeline model built from the bus protocol rules.
module tb_serial_bus_master;

   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          M_VALID;
   logic          M_RW;
   logic [AW-1:0] M_ADDR;
   logic [DW-1:0] M_WDATA;
   logic          M_READY;
   logic          M_DONE;
   logic          M_ERR;
   logic [DW-1:0] M_RDATA;
   logic          AD_SEL;
   logic          B_RW;
   logic          B_BUS_OUT;
   logic          B_BUS_IN;
   logic          B_ACK;
   logic          B_SBSY;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] last_rd;

   serial_bus_master #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .ACK_TIMEOUT(TO)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .M_VALID(M_VALID),
      .M_RW(M_RW),
      .M_ADDR(M_ADDR),
      .M_WDATA(M_WDATA),
      .M_READY(M_READY),
      .M_DONE(M_DONE),
      .M_ERR(M_ERR),
      .M_RDATA(M_RDATA),
      .AD_SEL(AD_SEL),
      .B_RW(B_RW),
      .B_BUS_OUT(B_BUS_OUT),
      .B_BUS_IN(B_BUS_IN),
      .B_ACK(B_ACK),
      .B_SBSY(B_SBSY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave answers on wait cycle d (0-based); d >= TO means no answer
   task automatic ack_phase(input logic rw, input int d, input bit is_a,
                            output bit ok);
      ok = 1'b0;
      for (int k = 0; k < TO; k++) begin
         @(negedge CLK);
         B_SBSY = 1'($urandom);
         chk("ack_sel", AD_SEL, 0);
         chk("ack_rw", B_RW, rw);
         chk("ack_ready", M_READY, 0);
         chk("ack_flags", {M_DONE, M_ERR}, 0);
         if (is_a) chk("ack_a_bus", B_BUS_OUT, 0);
         B_ACK = (k == d);
         if (k == d) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic end_check(input bit done, input logic [DW-1:0] rd_exp);
      @(negedge CLK);
      B_ACK = 1'($urandom);
      chk("end_done", M_DONE, done);
      chk("end_err", M_ERR, !done);
      chk("end_ready", M_READY, 1);
      chk("end_rw", B_RW, 0);
      chk("end_rdata", M_RDATA, rd_exp);
   endtask

   task automatic txn(input logic rw, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input int da, input int dw, input bit hold,
                      input int abort_at);
      bit ok;
      M_VALID = 1'b1;
      M_RW    = rw;
      M_ADDR  = a;
      M_WDATA = wd;
      B_ACK   = 1'b0;
      chk("start_ready", M_READY, 1);
      for (int i = 0; i < AW; i++) begin
         @(negedge CLK);
         if (hold) begin
            M_ADDR  = AW'($urandom);
            M_WDATA = DW'($urandom);
            M_RW    = 1'($urandom);
         end else begin
            M_VALID = 1'b0;
         end
         B_ACK  = 1'($urandom);
         B_SBSY = 1'($urandom);
         chk("addr_sel", AD_SEL, 1);
         chk("addr_bit", B_BUS_OUT, a[i]);
         chk("addr_rw", B_RW, rw);
         chk("addr_ready", M_READY, 0);
         chk("addr_flags", {M_DONE, M_ERR}, 0);
         if (i == abort_at) begin
            RST     = 1'b1;
            M_VALID = 1'b0;
            @(negedge CLK);
            RST     = 1'b0;
            last_rd = '0;
            chk("rst_sel", AD_SEL, 0);
            chk("rst_ready", M_READY, 1);
            chk("rst_flags", {M_DONE, M_ERR}, 0);
            chk("rst_rw", B_RW, 0);
            chk("rst_rdata", M_RDATA, 0);
            return;
         end
      end
      B_ACK = 1'b0;
      ack_phase(rw, da, 1'b1, ok);
      if (!ok) begin
         end_check(1'b0, last_rd);
         return;
      end
      for (int j = 0; j < DW; j++) begin
         @(negedge CLK);
         B_ACK    = 1'($urandom);
         B_BUS_IN = rw ? 1'($urandom) : rd[j];
         chk("data_sel", AD_SEL, 0);
         chk("data_rw", B_RW, rw);
         chk("data_flags", {M_DONE, M_ERR}, 0);
         if (rw) chk("wdata_bit", B_BUS_OUT, wd[j]);
      end
      if (rw) begin
         B_ACK = 1'b0;
         ack_phase(rw, dw, 1'b0, ok);
         end_check(ok, last_rd);
      end else begin
         last_rd = rd;
         end_check(1'b1, last_rd);
      end
   endtask

   task automatic idle(input int n);
      M_VALID = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         B_ACK = 1'($urandom);
         chk("idle_ready", M_READY, 1);
         chk("idle_flags", {M_DONE, M_ERR}, 0);
         chk("idle_sel", AD_SEL, 0);
         chk("idle_rw", B_RW, 0);
      end
   endtask

   initial begin
      RST      = 1'b1;
      M_VALID  = 1'b0;
      M_RW     = 1'b0;
      M_ADDR   = '0;
      M_WDATA  = '0;
      B_BUS_IN = 1'b0;
      B_ACK    = 1'b0;
      B_SBSY   = 1'b0;
      last_rd  = '0;
      repeat (2) @(negedge CLK);
      chk("reset_ready", M_READY, 1);
      chk("reset_sel", AD_SEL, 0);
      chk("reset_rw", B_RW, 0);
      chk("reset_bus", B_BUS_OUT, 0);
      chk("reset_flags", {M_DONE, M_ERR}, 0);
      chk("reset_rdata", M_RDATA, 0);
      RST = 1'b0;
      idle(1);

      txn(1'b1, 16'h1234, 8'hA5, 8'h00, 0, 0, 1'b0, -1);
      idle(1);
      txn(1'b0, 16'h0004, 8'h00, 8'h3C, 0, 0, 1'b0, -1);
      txn(1'b1, 16'h4321, 8'h77, 8'h00, TO, 0, 1'b0, -1);
      txn(1'b1, 16'hBEEF, 8'h5A, 8'h00, 0, 0, 1'b0, 7);
      txn(1'b1, 16'h0F0F, 8'hC3, 8'h00, 1, 2, 1'b0, -1);
      txn(1'b1, 16'hAAAA, 8'h11, 8'h00, 0, 0, 1'b1, -1);
      txn(1'b0, 16'h5555, 8'h00, 8'h96, 2, 0, 1'b0, -1);
      txn(1'b1, 16'h1357, 8'h24, 8'h00, 0, TO - 1, 1'b0, -1);
      txn(1'b1, 16'h2468, 8'h81, 8'h00, 0, TO, 1'b0, -1);
      txn(1'b0, 16'h7777, 8'h00, 8'hFF, TO + 1, 0, 1'b0, -1);
      idle(2);

      for (int n = 0; n < 30; n++) begin
         txn(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
             int'($urandom_range(0, TO + 1)), int'($urandom_range(0, TO + 1)),
             1'b0, (($urandom_range(0, 9) == 0) ? int'($urandom_range(0, AW - 1)) : -1));
         idle(int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
